// File: rtl/wm8731_i2c_cfg_seq.sv
// wm8731_i2c_cfg_seq: single-master I2C write sequencer that loads the WM8731 codec with a fixed 11-entry
//   register table. Each entry is the 3-byte write 0x34, {reg[6:0],data[8]}, data[7:0].
// Latency: one quarter-bit = CLK_HZ/(4*I2C_HZ) clocks. One entry = 120 quarters, full table = 1320 quarters.
// Flow control: start is accepted only while not busy. It is ignored while busy.
// Ports: clk, reset (synchronous, active-high); start (1-cycle pulse); sdat_i (sampled SDAT pin level);
//   sdat_oe (1 = pull SDAT low); sclk (push-pull); busy; done/ack_err (sticky until next start);
//   err_index (entry of the failing NACK, 0 when none).
// Build option: define AUDIO_CFG_RETRY_EN to re-send a NACKed entry up to MAX_RETRY times before aborting.
module wm8731_i2c_cfg_seq #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int I2C_HZ     = 100_000,
  parameter bit AUTO_START = 1'b1,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sdat_i,
  output logic       sdat_oe,
  output logic       sclk,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [3:0] err_index
);

  localparam int              QDIV     = CLK_HZ / (4 * I2C_HZ);
  localparam int              QW       = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0]   QLAST    = QW'(QDIV - 1);
  localparam logic [3:0]      LAST_IDX = 4'd10;
  localparam logic [7:0]      DEV_ADDR = 8'h34;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qtr_q, qtr_d;      // quarter within the current bit/condition
  logic [2:0]    bit_q, bit_d;      // bit within byte, MSB first
  logic [1:0]    byte_q, byte_d;    // byte within entry
  logic [3:0]    idx_q, idx_d;      // table entry
  logic          nack_q, nack_d;    // NACK seen during the current entry
  logic          auto_q, auto_d;    // pending one-shot auto start
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic [3:0]    err_idx_q, err_idx_d;

  logic          tick;
  logic          qend;
  logic [15:0]   entry;
  logic [7:0]    tx_byte;
  logic          tx_bit;
  logic          retry_ok;

  // Table row packed as {reg[6:0], data[8:0]}.
  function automatic logic [15:0] table_entry(input logic [3:0] i);
    logic [15:0] e;
    case (i)
      4'd0:    e = {7'd15, 9'h000};
      4'd1:    e = {7'd0,  9'h017};
      4'd2:    e = {7'd1,  9'h017};
      4'd3:    e = {7'd2,  9'h079};
      4'd4:    e = {7'd3,  9'h079};
      4'd5:    e = {7'd4,  9'h012};
      4'd6:    e = {7'd5,  9'h000};
      4'd7:    e = {7'd6,  9'h000};
      4'd8:    e = {7'd7,  9'h042};
      4'd9:    e = {7'd8,  9'h000};
      4'd10:   e = {7'd9,  9'h001};
      default: e = '0;
    endcase
    return e;
  endfunction

  // The quarter counter only runs while a sequence is active.
  assign tick = (state_q != S_IDLE) && (state_q != S_DONE) && (qcnt_q == QLAST);
  assign qend = tick && (qtr_q == 2'd3);

  always_comb begin
    entry = table_entry(idx_q);
    case (byte_q)
      2'd0:    tx_byte = DEV_ADDR;
      2'd1:    tx_byte = entry[15:8];   // {reg[6:0], data[8]}
      default: tx_byte = entry[7:0];
    endcase
    tx_bit = tx_byte[3'd7 - bit_q];
  end

`ifdef AUDIO_CFG_RETRY_EN
  localparam int            RW   = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;

  assign retry_ok = (retry_q != RMAX);

  always_ff @(posedge clk) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    idx_d     = idx_q;
    nack_d    = nack_q;
    auto_d    = auto_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ack_err_d = ack_err_q;
    err_idx_d = err_idx_q;
`ifdef AUDIO_CFG_RETRY_EN
    retry_d   = retry_q;
`endif
    sclk      = 1'b1;
    sdat_oe   = 1'b0;
    qcnt_d    = '0;

    if ((state_q != S_IDLE) && (state_q != S_DONE) && !tick) qcnt_d = qcnt_q + 1'b1;
    if (tick) qtr_d = qtr_q + 2'd1;   // 2-bit wrap gives the 4-quarter cycle

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE lasts one cycle (the cycle busy is low and done is high) and returns to IDLE.
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start || auto_q) begin
          state_d   = S_START;
          qtr_d     = 2'd0;
          idx_d     = 4'd0;
          nack_d    = 1'b0;
          auto_d    = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          ack_err_d = 1'b0;
          err_idx_d = 4'd0;
`ifdef AUDIO_CFG_RETRY_EN
          retry_d   = '0;
`endif
        end
      end
      S_START: begin
        // SDA falls in q1 while SCL is high. SCL then drops in q3.
        sclk    = (qtr_q != 2'd3);
        sdat_oe = (qtr_q != 2'd0);
        if (qend) begin
          state_d = S_BIT;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          nack_d  = 1'b0;
        end
      end
      S_BIT: begin
        sclk    = qtr_q[0] ^ qtr_q[1];   // high in q1 and q2
        sdat_oe = ~tx_bit;
        if (qend) begin
          bit_d = bit_q + 3'd1;          // wraps to 0 after bit 7
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: begin
        sclk = qtr_q[0] ^ qtr_q[1];
        // Sample on the tick that ends q1, mid SCL-high.
        if (tick && (qtr_q == 2'd1) && sdat_i) nack_d = 1'b1;
        if (qend) begin
          if (nack_q || (byte_q == 2'd2)) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = S_BIT;
          end
        end
      end
      S_STOP: begin
        // SCL rises in q1. SDA is released in q2 while SCL is high.
        sclk    = (qtr_q != 2'd0);
        sdat_oe = ~qtr_q[1];
        if (qend) state_d = S_GAP;
      end
      S_GAP: begin
        if (qend) begin
          if (nack_q && retry_ok) begin
            state_d = S_START;
`ifdef AUDIO_CFG_RETRY_EN
            retry_d = retry_q + 1'b1;
`endif
          end else if (nack_q || (idx_q == LAST_IDX)) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            ack_err_d = nack_q;
            err_idx_d = nack_q ? idx_q : 4'd0;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_START;
`ifdef AUDIO_CFG_RETRY_EN
            retry_d = '0;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      nack_q    <= 1'b0;
      auto_q    <= AUTO_START;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      nack_q    <= nack_d;
      auto_q    <= auto_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_err   = ack_err_q;
  assign err_index = err_idx_q;

endmodule

// File: tb/tb_wm8731_i2c_cfg_seq.sv
// tb_wm8731_i2c_cfg_seq: bench for wm8731_i2c_cfg_seq (CLK_HZ=800, I2C_HZ=100 -> 2 clocks per quarter).
// A bus-level codec model decodes START/bytes/STOP from sclk/SDA, ACKs or NACKs on request, and checks
// that SDA and SCL never change together. Expected transactions come from the register table by arithmetic.
module tb_wm8731_i2c_cfg_seq;

`ifdef AUDIO_CFG_RETRY_EN
  localparam int MAXR = 3;
`else
  localparam int MAXR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sdat_i;
  logic       sdat_oe;
  logic       sclk;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [3:0] err_index;
  logic       codec_low;

  // Open-drain SDAT: low if either side pulls it down.
  assign sdat_i = ~sdat_oe & ~codec_low;

  wm8731_i2c_cfg_seq #(
    .CLK_HZ(800), .I2C_HZ(100), .AUTO_START(1'b1), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sdat_i(sdat_i), .sdat_oe(sdat_oe),
    .sclk(sclk), .busy(busy), .done(done), .ack_err(ack_err), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int unsigned REGS [11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int unsigned DATA [11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h042, 'h000, 'h001};

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Transaction record: {byte count, b0, b1, b2}, missing bytes zero.
  function automatic logic [31:0] pack(int e, int n);
    logic [7:0] b1, b2;
    b1 = 8'((REGS[e] << 1) | (DATA[e] >> 8));
    b2 = 8'(DATA[e] & 'hFF);
    return {8'(n), 8'h34, (n >= 2) ? b1 : 8'h00, (n >= 3) ? b2 : 8'h00};
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int  exp_cyc;
  bit  exp_err;
  int  exp_idx;

  // Reference: walk the table, NACKing entry ne at byte nb for the first lim attempts.
  task automatic build_exp(int ne, int nb, int lim);
    int given, retries;
    bit stop;
    exp_q.delete();
    exp_err = 0; exp_idx = 0; exp_cyc = 0; given = 0; stop = 0;
    for (int e = 0; e < 11 && !stop; e++) begin
      retries = 0;
      while (!stop) begin
        if (e == ne && given < lim) begin
          given++;
          exp_q.push_back(pack(e, nb + 1));
          exp_cyc += 2 * (12 + 36 * (nb + 1));
          if (retries < MAXR) retries++;
          else begin exp_err = 1; exp_idx = e; stop = 1; end
        end else begin
          exp_q.push_back(pack(e, 3));
          exp_cyc += 2 * 120;
          break;
        end
      end
    end
  endtask

  // Codec / bus monitor state.
  bit         prev_scl = 1, prev_sda = 1, in_txn = 0, txn_nacked = 0;
  int         bitn = 0, ncur = 0, proto_err = 0, busy_cyc = 0, entry_ctr = 0;
  int         nack_e = -1, nack_b = 0, nack_lim = 0, nack_given = 0;
  logic [7:0] shreg = 0;
  logic [7:0] cur_b [3];

  always @(negedge clk) begin
    bit scl, sda;
    scl = sclk;
    sda = sdat_i;
    if (busy === 1'b1) busy_cyc++;
    if ((sda != prev_sda) && (scl != prev_scl)) proto_err++;
    if (prev_scl && scl && prev_sda && !sda) begin
      if (in_txn) proto_err++;
      in_txn = 1; bitn = 0; ncur = 0; txn_nacked = 0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      if (in_txn) begin
        got_q.push_back({8'(ncur), cur_b[0], (ncur >= 2) ? cur_b[1] : 8'h00, (ncur >= 3) ? cur_b[2] : 8'h00});
        if (ncur == 3 && !txn_nacked) entry_ctr++;
      end
      in_txn = 0;
    end else if (in_txn && !prev_scl && scl) begin
      if (bitn < 8) begin
        shreg = {shreg[6:0], sda};
        bitn++;
        if (bitn == 8) begin
          if (ncur < 3) begin cur_b[ncur] = shreg; ncur++; end
          else proto_err++;
        end
      end else begin
        bitn = 9;
      end
    end else if (in_txn && prev_scl && !scl) begin
      if (bitn == 8) begin
        if (entry_ctr == nack_e && (ncur - 1) == nack_b && nack_given < nack_lim) begin
          nack_given++; txn_nacked = 1; codec_low = 0;
        end else begin
          codec_low = 1;
        end
      end else if (bitn == 9) begin
        codec_low = 0; bitn = 0;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called only while the bus is idle.
  task automatic clear_model(int ne, int nb, int lim);
    got_q.delete();
    proto_err = 0; busy_cyc = 0; entry_ctr = 0; nack_given = 0;
    nack_e = ne; nack_b = nb; nack_lim = lim;
    in_txn = 0; bitn = 0; codec_low = 0; prev_scl = 1; prev_sda = 1;
    build_exp(ne, nb, lim);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_wait(string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, " busy_rise"}, 64'(busy), 64'd1);
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    check({tag, " finish_in_bound"}, 64'(n < 20000), 64'd1);
  endtask

  task automatic check_run(string tag);
    check({tag, " txn_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s txn%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " ack_err"}, 64'(ack_err), 64'(exp_err));
    check({tag, " err_index"}, 64'(err_index), 64'(exp_idx));
    check({tag, " busy_cycles"}, 64'(busy_cyc), 64'(exp_cyc));
    check({tag, " protocol"}, 64'(proto_err), 64'd0);
    check({tag, " bus_idle"}, {62'd0, sclk, sdat_oe}, 64'd2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset = 1'b1;
    start = 1'b0;
    codec_low = 1'b0;
    clear_model(-1, 0, 0);
    repeat (5) @(negedge clk);
    check("reset sclk", 64'(sclk), 64'd1);
    check("reset sdat_oe", 64'(sdat_oe), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset flags", {61'd0, done, ack_err, 1'b0} | 64'(err_index), 64'd0);

    // 1: auto start after reset release.
    reset = 1'b0;
    @(negedge clk);
    check("T1 busy_next_cycle", 64'(busy), 64'd1);
    run_wait("T1");
    check_run("T1");
    check("T1 first_txn", 64'((got_q.size() > 0) ? got_q[0] : 32'h0), 64'h03341E00);
    check("T1 entry8_txn", 64'((got_q.size() > 8) ? got_q[8] : 32'h0), 64'h03340E42);

    // 2: no second auto run; idle until an explicit start.
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (busy !== 1'b0 || sclk !== 1'b1 || sdat_oe !== 1'b0) bad++;
    end
    check("T2 idle_without_start", 64'(bad), 64'd0);
    clear_model(-1, 0, 0);
    pulse_start();
    run_wait("T2");
    check_run("T2");

    // 3: codec always NACKs the address byte of entry 4.
    clear_model(4, 0, 1000);
    pulse_start();
    run_wait("T3");
    check_run("T3");

    // 4: entry 4 NACKed twice at a random byte, then ACKed.
    clear_model(4, int'($urandom_range(0, 2)), 2);
    pulse_start();
    run_wait("T4");
    check_run("T4");

    // Random entry, byte and NACK count.
    clear_model(int'($urandom_range(0, 10)), int'($urandom_range(0, 2)), int'($urandom_range(1, 5)));
    pulse_start();
    run_wait("T4r");
    check_run("T4r");

    // 5: start pulses while busy are ignored.
    clear_model(-1, 0, 0);
    pulse_start();
    repeat (98) @(negedge clk);
    pulse_start();
    repeat (899) @(negedge clk);
    pulse_start();
    repeat ($urandom_range(10, 500)) @(negedge clk);
    pulse_start();
    run_wait("T5");
    check_run("T5");

    // 6: reset (with a coincident start) in the middle of entry 6.
    clear_model(-1, 0, 0);
    pulse_start();
    repeat (1440 + $urandom_range(10, 215)) @(negedge clk);
    check("T6 entries_before_reset", 64'(got_q.size()), 64'd6);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("T6 sclk_after_reset", 64'(sclk), 64'd1);
    check("T6 oe_after_reset", 64'(sdat_oe), 64'd0);
    check("T6 busy_after_reset", 64'(busy), 64'd0);
    check("T6 done_after_reset", 64'(done), 64'd0);
    @(negedge clk);
    clear_model(-1, 0, 0);
    reset = 1'b0;
    pulse_start();
    run_wait("T6");
    check_run("T6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
